interval_meter: RTL and testbench
=================================

Name: interval_meter

Overview:
- Measures time intervals; the counterpart to the countdown timer, which converts a loaded value into an elapsed interval.
- This block converts an elapsed interval back into a value: it counts enabled ticks between a start event and a stop event.
- It presents the result with a one-cycle done strobe.
- Used to characterise the timer's expiry pulses and external event spacing in the lab datapath.

Parameters:
WIDTH, 9, width of the tick counter and of measured_value (matches the timer load width)

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
count_en  input  1  tick qualifier; the counter advances only on cycles with count_en=1
start  input  1  single-cycle pulse; begins (or restarts) a measurement
stop  input  1  single-cycle pulse; ends the current measurement
measured_value  output  WIDTH  tick count of the last completed measurement, held until the next completion
done  output  1  one-cycle strobe, high on the cycle measured_value updates
busy  output  1  high while a measurement is in progress (state RUN)
overflow  output  1  high if the last completed measurement saturated, held with measured_value

Behaviour:
- Reset (reset=0, asynchronous):
  - State IDLE; internal count=0.
  - measured_value=0, done=0, busy=0, overflow=0.
  - Reset asserted mid-measurement aborts it with no done strobe.
- All outputs are registered; none is combinational from inputs.
- FSM states: IDLE, RUN.
- IDLE:
  - start=1 -> RUN next cycle, count cleared to 0, sat flag cleared.
  - stop is ignored.
  - count_en is ignored.
- RUN:
  - busy=1.
  - Each cycle with count_en=1 increments count by 1.
  - At 2^WIDTH-1 the count saturates, with no wrap-around, and an internal sat flag sets.
- stop=1 in RUN:
  - On the next edge, measured_value <= count + (count_en ? 1 : 0), saturated; the tick in the stop cycle is counted.
  - overflow <= sat flag, including a saturation caused by that final tick.
  - done=1 for exactly that one cycle; state -> IDLE; busy=0.
- start=1 in RUN (stop=0): count restarts from 0, sat cleared, state stays RUN, no done strobe. A tick in the same cycle is not counted.
- start=1 and stop=1 in the same cycle:
  - In RUN: stop takes priority; the measurement completes as above. The following state is per the Optional Feature.
  - In IDLE: start takes priority; the block enters RUN.
- Latency: start to busy=1 is 1 cycle; stop to done=1 is 1 cycle. Back-to-back measurements can complete on every other cycle.
- A start with stop on the next cycle and count_en=0 throughout gives measured_value=0 with done=1 (zero-length interval is legal).
- done is never high on two consecutive cycles in non-auto-restart mode.

Optional Feature:
INTERVAL_METER_AUTORESTART_EN
- Defined:
  - stop in RUN completes the measurement as normal but stays in RUN, with count reloaded so the next interval begins immediately.
  - The reloaded count is 0; a tick in the stop cycle is attributed to the completed interval.
  - Gives continuous period measurement from a single stop pulse train.
  - busy stays 1; start still restarts.
  - done may strobe on consecutive cycles.
- Not defined: stop returns to IDLE as described in Behaviour.

Test Plan:
- Reset release, then start, 5 cycles with count_en=1, then stop (count_en=0) -> done=1 one cycle later, measured_value=5, overflow=0, busy=0 after.
- start, count_en high every other cycle for 8 cycles (4 ticks), stop with count_en=1 in the same cycle -> measured_value=5.
- WIDTH=9, start, 600 consecutive ticks, stop -> measured_value=511, overflow=1; next measurement of 3 ticks -> measured_value=3, overflow=0.
- start, 3 ticks, start again, 2 ticks, stop -> single done, measured_value=2; a stop pulse in IDLE -> no done, measured_value unchanged.
- Assert reset=0 mid-RUN after 4 ticks -> busy=0, measured_value=0, no done; start+stop together in IDLE -> busy=1 next cycle.
- With INTERVAL_METER_AUTORESTART_EN: start, then stops after 3, 4 and 2 ticks -> done strobes with values 3, 4, 2; busy stays 1 throughout.

Source files
------------

// File: rtl/interval_meter.sv
// Counts enabled ticks between start and stop pulses; result held with a done strobe.
// Define INTERVAL_METER_AUTORESTART_EN to keep measuring back-to-back intervals on each stop.
module interval_meter #(
   parameter int WIDTH = 9
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             count_en,
   input  logic             start,
   input  logic             stop,
   output logic [WIDTH-1:0] measured_value,
   output logic             done,
   output logic             busy,
   output logic             overflow
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [WIDTH-1:0] MAX = '1;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             sat_q, sat_d;
   logic [WIDTH-1:0] meas_q, meas_d;
   logic             done_q, done_d;
   logic             ovf_q, ovf_d;
   logic [WIDTH:0]   sum;
   logic             sum_sat;

   // One extra bit so the tick at full scale is seen before clamping.
   assign sum     = {1'b0, count_q} + {{WIDTH{1'b0}}, count_en};
   assign sum_sat = (sum >= {1'b0, MAX});

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         count_q <= '0;
         sat_q   <= 1'b0;
         meas_q  <= '0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         sat_q   <= sat_d;
         meas_q  <= meas_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      sat_d   = sat_q;
      meas_d  = meas_q;
      done_d  = 1'b0;
      ovf_d   = ovf_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               count_d = '0;
               sat_d   = 1'b0;
            end
         end
         RUN: begin
            if (stop) begin
               meas_d  = sum_sat ? MAX : sum[WIDTH-1:0];
               ovf_d   = sat_q | sum_sat;
               done_d  = 1'b1;
               count_d = '0;
               sat_d   = 1'b0;
`ifdef INTERVAL_METER_AUTORESTART_EN
               state_d = RUN;
`else
               state_d = IDLE;
`endif
            end else if (start) begin
               count_d = '0;
               sat_d   = 1'b0;
            end else if (count_en) begin
               count_d = sum_sat ? MAX : sum[WIDTH-1:0];
               sat_d   = sat_q | sum_sat;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign measured_value = meas_q;
   assign done           = done_q;
   assign busy           = (state_q == RUN);
   assign overflow       = ovf_q;

endmodule

// File: tb/tb_interval_meter.sv
// Directed bench for interval_meter: hand-computed values checked with immediate assertions.
module tb_interval_meter;

   localparam int WIDTH = 9;

   logic             clock = 1'b0;
   logic             reset = 1'b0;
   logic             count_en = 1'b0;
   logic             start = 1'b0;
   logic             stop = 1'b0;
   logic [WIDTH-1:0] measured_value;
   logic             done;
   logic             busy;
   logic             overflow;

   int passed = 0;
   int total  = 0;

   interval_meter #(.WIDTH(WIDTH)) dut (
      .clock          (clock),
      .reset          (reset),
      .count_en       (count_en),
      .start          (start),
      .stop           (stop),
      .measured_value (measured_value),
      .done           (done),
      .busy           (busy),
      .overflow       (overflow)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic ticks(input int n);
      count_en = 1'b1;
      repeat (n) step();
      count_en = 1'b0;
   endtask

   task automatic do_stop(input logic en);
      count_en = en;
      stop = 1'b1;
      step();
      stop = 1'b0;
      count_en = 1'b0;
   endtask

   initial begin
      #12;
      chk("rst_val", measured_value, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ovf", overflow, 0);
      @(negedge clock);
      reset = 1'b1;
      step();

`ifdef INTERVAL_METER_AUTORESTART_EN
      pulse_start();
      chk("ar_busy0", busy, 1);
      ticks(3);
      do_stop(1'b0);
      chk("ar_done1", done, 1);
      chk("ar_val1", measured_value, 3);
      chk("ar_busy1", busy, 1);
      ticks(4);
      do_stop(1'b0);
      chk("ar_done2", done, 1);
      chk("ar_val2", measured_value, 4);
      chk("ar_busy2", busy, 1);
      ticks(2);
      do_stop(1'b0);
      chk("ar_done3", done, 1);
      chk("ar_val3", measured_value, 2);
      chk("ar_busy3", busy, 1);
      do_stop(1'b0);
      chk("ar_zero_done", done, 1);
      chk("ar_zero_val", measured_value, 0);
`else
      // basic 5-tick interval
      pulse_start();
      chk("t1_busy", busy, 1);
      ticks(5);
      chk("t1_nodone", done, 0);
      do_stop(1'b0);
      chk("t1_done", done, 1);
      chk("t1_val", measured_value, 5);
      chk("t1_ovf", overflow, 0);
      chk("t1_busy", busy, 0);
      step();
      chk("t1_done_clr", done, 0);
      chk("t1_hold", measured_value, 5);

      // alternating ticks plus a tick in the stop cycle
      pulse_start();
      for (int i = 0; i < 8; i++) begin
         count_en = (i % 2 == 0);
         step();
      end
      do_stop(1'b1);
      chk("t2_done", done, 1);
      chk("t2_val", measured_value, 5);

      // saturation then recovery
      pulse_start();
      ticks(600);
      do_stop(1'b0);
      chk("t3_done", done, 1);
      chk("t3_val", measured_value, 511);
      chk("t3_ovf", overflow, 1);
      pulse_start();
      ticks(3);
      do_stop(1'b0);
      chk("t3b_val", measured_value, 3);
      chk("t3b_ovf", overflow, 0);

      // restart mid-measurement
      pulse_start();
      ticks(3);
      count_en = 1'b1;
      pulse_start();
      count_en = 1'b0;
      chk("t4_restart_nodone", done, 0);
      chk("t4_restart_busy", busy, 1);
      ticks(2);
      do_stop(1'b0);
      chk("t4_done", done, 1);
      chk("t4_val", measured_value, 2);
      step();
      chk("t4_single", done, 0);
      do_stop(1'b0);
      chk("t4_idle_stop_done", done, 0);
      chk("t4_idle_stop_val", measured_value, 2);

      // zero-length interval
      pulse_start();
      do_stop(1'b0);
      chk("t5_done", done, 1);
      chk("t5_val", measured_value, 0);

      // async reset mid-run
      pulse_start();
      ticks(4);
      #2 reset = 1'b0;
      #1;
      chk("t6_busy", busy, 0);
      chk("t6_val", measured_value, 0);
      chk("t6_done", done, 0);
      @(negedge clock);
      reset = 1'b1;
      step();
      chk("t6_done_after", done, 0);

      // start and stop together in IDLE
      start = 1'b1;
      stop  = 1'b1;
      step();
      start = 1'b0;
      stop  = 1'b0;
      chk("t7_busy", busy, 1);
      chk("t7_nodone", done, 0);
      do_stop(1'b1);
      chk("t7_val", measured_value, 1);
      chk("t7_idle", busy, 0);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
